// File: rtl/scope_pkg.sv
// Shared types and defaults for the roll-mode display buffer.
// Holds the controller state encoding and the decimation limit helper.
package scope_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int DEPTH_DEF  = 640;
  localparam int ADDR_W_DEF = 10;
  localparam int DEC_W      = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_ROLL = 2'd2
  } state_t;

  // Last dec_cnt value of a window; a factor of 0 behaves like 1.
  function automatic logic [DEC_W-1:0] dec_limit(input logic [DEC_W-1:0] factor);
    return (factor == '0) ? '0 : factor - 1'b1;
  endfunction

endpackage

// File: rtl/roll_ram.sv
// Simple dual-port column store with registered read and no reset,
// so it maps onto a block RAM. A same-address read during a write returns old data.
module roll_ram #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 640,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/roll_buffer.sv
// Roll-mode oscilloscope buffer: decimates (last or peak) incoming samples into
// columns and reads them back with the newest column at the right edge.
module roll_buffer
  import scope_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [DATA_W-1:0] sample_in,
  input  logic              sample_valid,
  input  logic [15:0]       dec_factor,
  input  logic              peak_en,
  input  logic [ADDR_W-1:0] rd_col,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              col_tick,
  output logic              full
);

  localparam logic [ADDR_W:0]   DEPTH_X  = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

  state_t            state;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W:0]   fill_cnt;
  logic [DEC_W-1:0]  dec_cnt;
  logic [DATA_W-1:0] peak_reg;
  logic              rd_valid_reg;

  logic [DEC_W-1:0]  dec_lim;
  logic              running;
  logic              win_end;
  logic              do_write;
  logic [DATA_W-1:0] peak_next;
  logic [DATA_W-1:0] wr_data;
  logic [ADDR_W-1:0] wr_ptr_inc;
  logic [ADDR_W:0]   rd_col_x;
  logic [ADDR_W:0]   roll_sum;
  logic              col_in_range;
  logic              rd_ok;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] ram_q;

  // Write path: a window closes on the valid sample reaching the limit, which
  // also lets a lowered dec_factor take effect on the very next sample.
  always_comb begin
    dec_lim    = dec_limit(dec_factor);
    running    = enable && (state != ST_IDLE);
    win_end    = (dec_cnt >= dec_lim);
    do_write   = running && sample_valid && win_end;
    peak_next  = (sample_in > peak_reg) ? sample_in : peak_reg;
    wr_data    = peak_en ? peak_next : sample_in;
    wr_ptr_inc = (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
  end

  // Read path: once full, column 0 maps to the oldest entry, which is wr_ptr.
  always_comb begin
    rd_col_x     = {1'b0, rd_col};
    col_in_range = (rd_col_x < DEPTH_X);
    roll_sum     = {1'b0, wr_ptr} + rd_col_x;
    rd_ok        = col_in_range && (full || (rd_col_x < fill_cnt));
    rd_addr      = '0;
    if (col_in_range) begin
      if (full) begin
        rd_addr = ADDR_W'((roll_sum >= DEPTH_X) ? roll_sum - DEPTH_X : roll_sum);
      end else begin
        rd_addr = rd_col;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      wr_ptr       <= '0;
      fill_cnt     <= '0;
      dec_cnt      <= '0;
      peak_reg     <= '0;
      col_tick     <= 1'b0;
      full         <= 1'b0;
      rd_valid_reg <= 1'b0;
    end else begin
      col_tick     <= do_write;
      rd_valid_reg <= rd_ok;
      case (state)
        ST_IDLE: begin
          if (enable) begin
            state    <= ST_FILL;
            wr_ptr   <= '0;
            fill_cnt <= '0;
            dec_cnt  <= '0;
            peak_reg <= '0;
            full     <= 1'b0;
          end
        end
        ST_FILL, ST_ROLL: begin
          if (!enable) begin
            state <= ST_IDLE;
          end else if (sample_valid) begin
            if (win_end) begin
              dec_cnt  <= '0;
              peak_reg <= '0;
              wr_ptr   <= wr_ptr_inc;
              if (!full) begin
                fill_cnt <= fill_cnt + 1'b1;
                if (fill_cnt == DEPTH_X - 1'b1) begin
                  state <= ST_ROLL;
                  full  <= 1'b1;
                end
              end
            end else begin
              dec_cnt  <= dec_cnt + 1'b1;
              peak_reg <= peak_next;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  roll_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .wr_en   (do_write),
    .wr_addr (wr_ptr),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_data (ram_q)
  );

  // Masking by the reset-cleared valid flag keeps rd_data at 0 without resetting the RAM.
  assign rd_valid = rd_valid_reg;
  assign rd_data  = rd_valid_reg ? ram_q : '0;

endmodule

// File: tb/tb_roll_buffer.sv
// Directed bench for roll_buffer: decimation, peak capture, fill/roll addressing,
// read validity, dec_factor changes, freeze and asynchronous reset.
module tb_roll_buffer;

  localparam int DW = 10;
  localparam int DP = 640;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic [DW-1:0] sample_in = '0;
  logic          sample_valid = 1'b0;
  logic [15:0]   dec_factor = 16'd1;
  logic          peak_en = 1'b0;
  logic [AW-1:0] rd_col = '0;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          col_tick;
  logic          full;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  roll_buffer #(.DATA_W(DW), .DEPTH(DP), .ADDR_W(AW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .dec_factor   (dec_factor),
    .peak_en      (peak_en),
    .rd_col       (rd_col),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .col_tick     (col_tick),
    .full         (full)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One valid sample; outputs sampled 1 ns after the edge that consumed it.
  task automatic send(input int v);
    sample_in    = DW'(v);
    sample_valid = 1'b1;
    step();
    sample_valid = 1'b0;
  endtask

  task automatic read_col(input int c, output logic [DW-1:0] d, output logic v);
    rd_col = AW'(c);
    step();
    d = rd_data;
    v = rd_valid;
    $display("read col=%0d data=%0d valid=%0b", c, d, v);
  endtask

  task automatic restart();
    enable = 1'b0;
    step();
    enable = 1'b1;
    step();
  endtask

  task automatic test_reset();
    #1;
    checks++; if (rd_data !== '0) begin errors++; $display("FAIL reset_rd_data got=%0d exp=0", rd_data); end
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid got=%0b exp=0", rd_valid); end
    checks++; if (col_tick !== 1'b0) begin errors++; $display("FAIL reset_col_tick got=%0b exp=0", col_tick); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got=%0b exp=0", full); end
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_decimate();
    logic [DW-1:0] d;
    logic v;
    int exp_col [3] = '{4, 8, 12};
    restart();
    dec_factor = 16'd4;
    peak_en = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      send(i);
      checks++;
      if (col_tick !== ((i % 4) == 0)) begin
        errors++; $display("FAIL dec_tick sample=%0d got=%0b exp=%0b", i, col_tick, (i % 4) == 0);
      end
    end
    for (int c = 0; c < 3; c++) begin
      read_col(c, d, v);
      checks++;
      if (d !== DW'(exp_col[c]) || v !== 1'b1) begin
        errors++; $display("FAIL dec_col%0d got=%0d/%0b exp=%0d/1", c, d, v, exp_col[c]);
      end
    end
    read_col(3, d, v);
    checks++; if (v !== 1'b0) begin errors++; $display("FAIL dec_col3_valid got=%0b exp=0", v); end
  endtask

  task automatic test_peak();
    logic [DW-1:0] d;
    logic v;
    int win [8] = '{9, 3, 7, 2, 1, 1, 1, 5};
    restart();
    dec_factor = 16'd4;
    peak_en = 1'b1;
    for (int i = 0; i < 8; i++) send(win[i]);
    read_col(0, d, v);
    checks++; if (d !== DW'(9) || v !== 1'b1) begin errors++; $display("FAIL peak_col0 got=%0d/%0b exp=9/1", d, v); end
    read_col(1, d, v);
    checks++; if (d !== DW'(5) || v !== 1'b1) begin errors++; $display("FAIL peak_col1 got=%0d/%0b exp=5/1", d, v); end
    peak_en = 1'b0;
  endtask

  task automatic test_valid_bound();
    logic [DW-1:0] d;
    logic v;
    restart();
    dec_factor = 16'd1;
    for (int i = 0; i < 10; i++) send(100 + i);
    read_col(9, d, v);
    checks++; if (d !== DW'(109) || v !== 1'b1) begin errors++; $display("FAIL bound_col9 got=%0d/%0b exp=109/1", d, v); end
    rd_col = AW'(10);
    #1;
    checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL bound_latency got=%0b exp=1", rd_valid); end
    step();
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL bound_col10 got=%0b exp=0", rd_valid); end
  endtask

  task automatic test_dec_change();
    logic [DW-1:0] d;
    logic v;
    int ticks;
    restart();
    dec_factor = 16'd0;
    for (int i = 0; i < 3; i++) begin
      send(11 + i);
      checks++; if (col_tick !== 1'b1) begin errors++; $display("FAIL dec0_tick sample=%0d got=%0b exp=1", i, col_tick); end
    end
    dec_factor = 16'd100;
    ticks = 0;
    for (int i = 0; i < 50; i++) begin
      send(200);
      if (col_tick) ticks++;
    end
    checks++; if (ticks != 0) begin errors++; $display("FAIL dec100_ticks got=%0d exp=0", ticks); end
    dec_factor = 16'd2;
    send(77);
    checks++; if (col_tick !== 1'b1) begin errors++; $display("FAIL dec_switch_tick got=%0b exp=1", col_tick); end
    read_col(3, d, v);
    checks++; if (d !== DW'(77) || v !== 1'b1) begin errors++; $display("FAIL dec_switch_col3 got=%0d/%0b exp=77/1", d, v); end
  endtask

  task automatic test_roll();
    logic [DW-1:0] d;
    logic v;
    restart();
    dec_factor = 16'd1;
    for (int i = 0; i < 700; i++) begin
      send(i);
      if (i == 638) begin
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL roll_full_639 got=%0b exp=0", full); end
      end
      if (i == 639) begin
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL roll_full_640 got=%0b exp=1", full); end
      end
    end
    read_col(639, d, v);
    checks++; if (d !== DW'(699) || v !== 1'b1) begin errors++; $display("FAIL roll_col639 got=%0d/%0b exp=699/1", d, v); end
    read_col(0, d, v);
    checks++; if (d !== DW'(60) || v !== 1'b1) begin errors++; $display("FAIL roll_col0 got=%0d/%0b exp=60/1", d, v); end
    read_col(320, d, v);
    checks++; if (d !== DW'(380) || v !== 1'b1) begin errors++; $display("FAIL roll_col320 got=%0d/%0b exp=380/1", d, v); end
    read_col(640, d, v);
    checks++; if (v !== 1'b0) begin errors++; $display("FAIL roll_col640_valid got=%0b exp=0", v); end
  endtask

  task automatic test_freeze();
    logic [DW-1:0] d;
    logic v;
    enable = 1'b0;
    step();
    for (int i = 0; i < 3; i++) begin
      send(5);
      checks++; if (col_tick !== 1'b0) begin errors++; $display("FAIL idle_tick sample=%0d got=%0b exp=0", i, col_tick); end
    end
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL idle_full got=%0b exp=1", full); end
    read_col(639, d, v);
    checks++; if (d !== DW'(699) || v !== 1'b1) begin errors++; $display("FAIL idle_col639 got=%0d/%0b exp=699/1", d, v); end
  endtask

  task automatic test_reset_mid_roll();
    logic [DW-1:0] d;
    logic v;
    restart();
    dec_factor = 16'd1;
    for (int i = 0; i < 645; i++) send(i);
    rd_col = '0;
    send(3);
    checks++; if (full !== 1'b1 || col_tick !== 1'b1 || rd_valid !== 1'b1) begin
      errors++; $display("FAIL mid_pre full=%0b tick=%0b valid=%0b exp=1/1/1", full, col_tick, rd_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL mid_full got=%0b exp=0", full); end
    checks++; if (col_tick !== 1'b0) begin errors++; $display("FAIL mid_tick got=%0b exp=0", col_tick); end
    checks++; if (rd_valid !== 1'b0 || rd_data !== '0) begin errors++; $display("FAIL mid_rd got=%0d/%0b exp=0/0", rd_data, rd_valid); end
    #1 rst_n = 1'b1;
    step();
    send(5);
    send(6);
    read_col(0, d, v);
    checks++; if (d !== DW'(5) || v !== 1'b1) begin errors++; $display("FAIL rst_col0 got=%0d/%0b exp=5/1", d, v); end
    read_col(1, d, v);
    checks++; if (d !== DW'(6) || v !== 1'b1) begin errors++; $display("FAIL rst_col1 got=%0d/%0b exp=6/1", d, v); end
    read_col(2, d, v);
    checks++; if (v !== 1'b0) begin errors++; $display("FAIL rst_col2_valid got=%0b exp=0", v); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL rst_full got=%0b exp=0", full); end
  endtask

  initial begin
    test_reset();
    test_decimate();
    test_peak();
    test_valid_bound();
    test_dec_change();
    test_roll();
    test_freeze();
    test_reset_mid_roll();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
